// File: rtl/timer_pkg.sv
// timer_pkg: shared state and mode types for timer_ctrl
package timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} timer_state_t;
  typedef enum logic {MODE_ONESHOT = 1'b0, MODE_PERIODIC = 1'b1} timer_mode_t;
endpackage

// File: rtl/counter.sv
// counter: up-counter with synchronous clear (priority) and enable
module counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) count_o <= '0;
    else if (clr_i) count_o <= '0;
    else if (en_i) count_o <= count_o + WIDTH'(1);
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: prescaled one-shot/periodic timer sequencing a prescaler and a period counter
// Define TIMER_CTRL_PAUSE_EN to add the pause_i port and the PAUSED state.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               mode_i,
  input  logic [WIDTH-1:0]   period_i,
  input  logic [PRESC_W-1:0] prescale_i,
`ifdef TIMER_CTRL_PAUSE_EN
  input  logic               pause_i,
`endif
  output logic               busy_o,
  output logic               tick_o,
  output logic               err_o,
  output logic [WIDTH-1:0]   count_o
);
  timer_state_t       r_state;
  timer_mode_t        r_mode;
  logic [WIDTH-1:0]   r_period;
  logic [PRESC_W-1:0] r_presc;
  logic               r_tick;
  logic               r_err;
  logic               w_pause;
  logic               w_idle;
  logic               w_active;
  logic               w_step;
  logic               w_expire;
  logic [PRESC_W-1:0] w_presc;
  logic [WIDTH-1:0]   w_cnt;
`ifdef TIMER_CTRL_PAUSE_EN
  assign w_pause = pause_i;
`else
  assign w_pause = 1'b0;
`endif
  // Pause gates counting on the very edge it is sampled, both entering and leaving PAUSED.
  assign w_idle   = r_state == IDLE;
  assign w_active = !w_idle && !stop_i && !w_pause;
  assign w_step   = w_active && w_presc == r_presc;
  assign w_expire = w_step && w_cnt == r_period - WIDTH'(1);
  counter #(.WIDTH(PRESC_W)) u_presc (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .clr_i(w_idle || stop_i || w_step), .en_i(w_active),
    .count_o(w_presc)
  );
  counter #(.WIDTH(WIDTH)) u_period (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .clr_i(w_idle || stop_i || w_expire), .en_i(w_step),
    .count_o(w_cnt)
  );
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      r_state  <= IDLE;
      r_mode   <= MODE_ONESHOT;
      r_period <= '0;
      r_presc  <= '0;
      r_tick   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_tick <= w_expire;
      r_err  <= w_idle && start_i && !stop_i && period_i == '0;
      if (w_idle) begin
        if (start_i && !stop_i && period_i != '0) begin
          r_state  <= RUN;
          r_mode   <= timer_mode_t'(mode_i);
          r_period <= period_i;
          r_presc  <= prescale_i;
        end
      end else if (stop_i) r_state <= IDLE;
      else if (w_expire && r_mode == MODE_ONESHOT) r_state <= IDLE;
      else r_state <= w_pause ? PAUSED : RUN;
    end
  assign busy_o  = !w_idle;
  assign tick_o  = r_tick;
  assign err_o   = r_err;
  assign count_o = w_cnt;
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed self-checking bench for timer_ctrl
// Pause scenarios run only when TIMER_CTRL_PAUSE_EN is defined.
module tb_timer_ctrl;
  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        mode_i = 1'b0;
  logic [15:0] period_i = '0;
  logic [7:0]  prescale_i = '0;
  logic        pause_i = 1'b0;
  logic        busy_o, tick_o, err_o;
  logic [15:0] count_o;
  int n_checks = 0;
  int n_fail = 0;
  timer_ctrl #(.WIDTH(16), .PRESC_W(8)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .stop_i(stop_i),
    .mode_i(mode_i), .period_i(period_i), .prescale_i(prescale_i),
`ifdef TIMER_CTRL_PAUSE_EN
    .pause_i(pause_i),
`endif
    .busy_o(busy_o), .tick_o(tick_o), .err_o(err_o), .count_o(count_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic edge1();
    @(posedge clk_i);
    #1;
  endtask
  task automatic outs(input string tag, input int busy, input int tick, input int cnt);
    check({tag, " busy"}, 32'(busy_o), 32'(busy));
    check({tag, " tick"}, 32'(tick_o), 32'(tick));
    check({tag, " count"}, 32'(count_o), 32'(cnt));
  endtask
  task automatic start(input logic mode, input int period, input int presc);
    mode_i = mode;
    period_i = 16'(period);
    prescale_i = 8'(presc);
    start_i = 1'b1;
    edge1();
    start_i = 1'b0;
  endtask
  initial begin
    #2;
    outs("reset", 0, 0, 0);
    check("reset err", 32'(err_o), 0);
    #10 rstn_i = 1'b1;
    edge1();
    start(1'b0, 4, 0);
    outs("oneshot e0", 1, 0, 0);
    for (int k = 1; k < 4; k++) begin
      edge1();
      outs($sformatf("oneshot e%0d", k), 1, 0, k);
    end
    edge1();
    outs("oneshot e4", 0, 1, 0);
    edge1();
    outs("oneshot e5", 0, 0, 0);
    start(1'b1, 3, 1);
    outs("periodic e0", 1, 0, 0);
    for (int k = 1; k <= 18; k++) begin
      edge1();
      outs($sformatf("periodic e%0d", k), 1, (k % 6 == 0) ? 1 : 0, (k / 2) % 3);
    end
    stop_i = 1'b1;
    edge1();
    stop_i = 1'b0;
    outs("periodic stop", 0, 0, 0);
    start(1'b1, 5, 0);
    for (int k = 1; k < 5; k++) begin
      edge1();
      outs($sformatf("p5 e%0d", k), 1, 0, k);
    end
    stop_i = 1'b1;
    edge1();
    stop_i = 1'b0;
    outs("stop at expiry", 0, 0, 0);
    edge1();
    outs("stop at expiry +1", 0, 0, 0);
    start(1'b0, 2, 0);
    outs("restart e0", 1, 0, 0);
    edge1();
    outs("restart e1", 1, 0, 1);
    edge1();
    outs("restart e2", 0, 1, 0);
    start(1'b0, 0, 0);
    check("zero period err", 32'(err_o), 1);
    outs("zero period", 0, 0, 0);
    edge1();
    check("zero period err drop", 32'(err_o), 0);
    stop_i = 1'b1;
    start(1'b0, 3, 0);
    stop_i = 1'b0;
    check("start+stop err", 32'(err_o), 0);
    outs("start+stop", 0, 0, 0);
    start(1'b1, 3, 0);
    edge1();
    edge1();
    edge1();
    outs("pre-reset tick", 1, 1, 0);
    #2 rstn_i = 1'b0;
    #1;
    outs("async reset", 0, 0, 0);
    #3 rstn_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      edge1();
      outs($sformatf("after reset %0d", k), 0, 0, 0);
    end
`ifdef TIMER_CTRL_PAUSE_EN
    start(1'b0, 4, 0);
    edge1();
    edge1();
    outs("pause pre", 1, 0, 2);
    pause_i = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      edge1();
      outs($sformatf("paused e%0d", k), 1, 0, 2);
    end
    pause_i = 1'b0;
    edge1();
    outs("resume e6", 1, 0, 3);
    edge1();
    outs("resume e7", 0, 1, 0);
    start(1'b0, 4, 0);
    edge1();
    pause_i = 1'b1;
    edge1();
    outs("pause hold", 1, 0, 1);
    stop_i = 1'b1;
    edge1();
    stop_i = 1'b0;
    pause_i = 1'b0;
    outs("stop in pause", 0, 0, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
